// File: rtl/execute_unit.sv
// Execute stage behind the 8 x 16-bit register bank.
// Single-cycle ALU ops write back on the edge after acceptance. MUL/DIVU/REMU
// iterate one bit per clock and write back WIDTH edges after acceptance.
//
// Handshake: an op is taken at a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. Operands are sampled only at that edge.
// in_valid while busy is ignored; the sender holds its values until accepted.
module execute_unit #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   output logic [WIDTH-1:0]  result,
   output logic [ADDR_W-1:0] rd_out,
   output logic              reg_write,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              flag_ovf,
   output logic              div_err,
   output logic              illegal_op,
   output logic [1:0]        dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOT   = 4'd5;
   localparam logic [3:0] OP_SLL   = 4'd6;
   localparam logic [3:0] OP_SRL   = 4'd7;
   localparam logic [3:0] OP_SRA   = 4'd8;
   localparam logic [3:0] OP_SLT   = 4'd9;
   localparam logic [3:0] OP_PASSB = 4'd10;
   localparam logic [3:0] OP_MUL   = 4'd11;
   localparam logic [3:0] OP_DIVU  = 4'd12;
   localparam logic [3:0] OP_REMU  = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   // MUL: sa = shifting multiplicand, sb = shifting multiplier, acc = product.
   // DIV: sa = divisor, sb = dividend shifting out / quotient shifting in,
   //      acc = partial remainder.
   logic [WIDTH-1:0]    sa;
   logic [WIDTH-1:0]    sb;
   logic [WIDTH-1:0]    acc;
   logic [ADDR_W-1:0]   rd_q;
   logic                is_rem;
   logic                div_zero;

   logic [WIDTH:0]      add_full;
   logic [WIDTH:0]      sub_full;
   logic [3:0]          shamt;
   logic [WIDTH-1:0]    alu_res;
   logic                alu_c;
   logic                alu_v;
   logic                alu_legal;

   logic [WIDTH-1:0]    mul_next;
   logic [WIDTH:0]      div_sh;
   logic                div_ge;
   logic [WIDTH-1:0]    div_rem_next;
   logic [WIDTH-1:0]    div_q_next;
   logic [WIDTH-1:0]    fin_res;
   logic                last_iter;

   assign add_full  = {1'b0, op_a} + {1'b0, op_b};
   // Top bit of the zero-extended difference is the unsigned borrow (a < b).
   assign sub_full  = {1'b0, op_a} - {1'b0, op_b};
   assign shamt     = op_b[3:0];
   assign dbg_state = state;

   // Single-cycle ALU result and ADD/SUB flags.
   always_comb begin
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_v     = 1'b0;
      alu_legal = 1'b1;
      case (op)
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (add_full[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_c   = sub_full[WIDTH];
            alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                      (sub_full[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND:   alu_res = op_a & op_b;
         OP_OR:    alu_res = op_a | op_b;
         OP_XOR:   alu_res = op_a ^ op_b;
         OP_NOT:   alu_res = ~op_a;
         OP_SLL:   alu_res = op_a << shamt;
         OP_SRL:   alu_res = op_a >> shamt;
         OP_SRA:   alu_res = $signed(op_a) >>> shamt;
         OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_PASSB: alu_res = op_b;
         default:  alu_legal = 1'b0;
      endcase
   end

   // One iteration of shift-add multiply / restoring divide.
   // With a zero divisor every trial subtract succeeds, so the quotient fills
   // with ones (all-ones result) and the dividend ends up in the remainder.
   always_comb begin
      mul_next     = acc + (sb[0] ? sa : '0);
      div_sh       = {acc, sb[WIDTH-1]};
      div_ge       = (div_sh >= {1'b0, sa});
      div_rem_next = div_ge ? (div_sh[WIDTH-1:0] - sa) : div_sh[WIDTH-1:0];
      div_q_next   = {sb[WIDTH-2:0], div_ge};
      last_iter    = (cnt == CW'(WIDTH - 1));
      if (state == S_MUL)
         fin_res = mul_next;
      else
         fin_res = is_rem ? div_rem_next : div_q_next;
   end

   // Control FSM, iteration datapath and registered write-back outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         sa         <= '0;
         sb         <= '0;
         acc        <= '0;
         rd_q       <= '0;
         is_rem     <= 1'b0;
         div_zero   <= 1'b0;
         in_ready   <= 1'b1;
         result     <= '0;
         rd_out     <= '0;
         reg_write  <= 1'b0;
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
         flag_ovf   <= 1'b0;
         div_err    <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         reg_write  <= 1'b0;
         illegal_op <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (op == OP_MUL) begin
                     state    <= S_MUL;
                     cnt      <= '0;
                     in_ready <= 1'b0;
                     sa       <= op_a;
                     sb       <= op_b;
                     acc      <= '0;
                     rd_q     <= rd_in;
                  end else if (op == OP_DIVU || op == OP_REMU) begin
                     state    <= S_DIV;
                     cnt      <= '0;
                     in_ready <= 1'b0;
                     sa       <= op_b;
                     sb       <= op_a;
                     acc      <= '0;
                     rd_q     <= rd_in;
                     is_rem   <= (op == OP_REMU);
                     div_zero <= (op_b == '0);
                  end else if (alu_legal) begin
                     result     <= alu_res;
                     rd_out     <= rd_in;
                     reg_write  <= 1'b1;
                     flag_zero  <= (alu_res == '0);
                     flag_carry <= alu_c;
                     flag_ovf   <= alu_v;
                     div_err    <= 1'b0;
                  end else begin
                     illegal_op <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc <= mul_next;
               sa  <= sa << 1;
               sb  <= sb >> 1;
            end
            S_DIV: begin
               acc <= div_rem_next;
               sb  <= div_q_next;
            end
            default: state <= S_IDLE;
         endcase

         if (state == S_MUL || state == S_DIV) begin
            if (last_iter) begin
               state      <= S_IDLE;
               in_ready   <= 1'b1;
               result     <= fin_res;
               rd_out     <= rd_q;
               reg_write  <= 1'b1;
               flag_zero  <= (fin_res == '0);
               flag_carry <= 1'b0;
               flag_ovf   <= 1'b0;
               div_err    <= (state == S_DIV) && div_zero;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: reset checks, a back-to-back table of single-cycle
// ops, then hand sequences for multiply/divide, illegal op and reset abort.
// Every write-back strobe is compared against an expected queue.
module tb_execute_unit;

   localparam int W  = 16;
   localparam int AW = 3;
   localparam int EW = AW + W + 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [3:0]    op = 4'd0;
   logic [AW-1:0] rd_in = '0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          in_ready;
   logic [W-1:0]  result;
   logic [AW-1:0] rd_out;
   logic          reg_write, flag_zero, flag_carry, flag_ovf, div_err, illegal_op;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected write-back: {rd, result, zero, carry, ovf, div_err}
   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [3:0]    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [AW-1:0] rd;
      logic [W-1:0]  res;
      logic          z;
      logic          c;
      logic          v;
   } vec_t;

   vec_t vecs[16];

   execute_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
      .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rd_in(rd_in), .op_a(op_a), .op_b(op_b),
      .result(result), .rd_out(rd_out), .reg_write(reg_write),
      .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
      .div_err(div_err), .illegal_op(illegal_op), .dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [EW-1:0] pack(input logic [AW-1:0] r, input logic [W-1:0] res,
                                          input logic z, input logic c, input logic v,
                                          input logic e);
      return {r, res, z, c, v, e};
   endfunction

   function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [AW-1:0] r, input logic [W-1:0] res,
                               input logic z, input logic c, input logic v);
      vec_t t;
      t.op = o; t.a = a; t.b = b; t.rd = r; t.res = res; t.z = z; t.c = c; t.v = v;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: every strobe must match the oldest expectation
   always @(negedge clk) begin
      if (reset_n && reg_write) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: got write rd=%0d result=%0h expected no write",
                     rd_out, result);
         end else begin
            chk("writeback", 32'(pack(rd_out, result, flag_zero, flag_carry, flag_ovf, div_err)),
                32'(exp_q.pop_front()));
         end
      end
   end

   task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] r);
      in_valid = 1'b1; op = o; op_a = a; op_b = b; rd_in = r;
   endtask

   task automatic run_single(input vec_t t);
      @(negedge clk); #1;
      drive(t.op, t.a, t.b, t.rd);
      exp_q.push_back(pack(t.rd, t.res, t.z, t.c, t.v, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic run_multi(input string name, input logic [3:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [AW-1:0] r,
                            input logic [W-1:0] res, input logic err);
      int lat;
      logic busy_ok;
      logic done;
      @(negedge clk); #1;
      drive(o, a, b, r);
      exp_q.push_back(pack(r, res, (res == '0), 1'b0, 1'b0, err));
      @(posedge clk); #1;
      // Keep in_valid high with a different op while busy; it must be ignored
      drive(4'd0, 16'h1111, 16'h2222, 3'd7);
      lat = 0; busy_ok = 1'b1; done = 1'b0;
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (reg_write) done = 1'b1;
         else if (in_ready !== 1'b0) busy_ok = 1'b0;
      end
      in_valid = 1'b0;
      chk({name, "_latency"}, lat, 16);
      chk({name, "_busy"}, 32'(busy_ok), 1);
      chk({name, "_ready_after"}, 32'(in_ready), 1);
      @(negedge clk); #1;
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(4'd0,  16'h7FFF, 16'h0001, 3'd3, 16'h8000, 0, 0, 1);
      vecs[1]  = mk(4'd1,  16'h0005, 16'h0007, 3'd1, 16'hFFFE, 0, 1, 0);
      vecs[2]  = mk(4'd2,  16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 0, 0, 0);
      vecs[3]  = mk(4'd0,  16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1, 1, 0);
      vecs[4]  = mk(4'd3,  16'h1200, 16'h0034, 3'd4, 16'h1234, 0, 0, 0);
      vecs[5]  = mk(4'd4,  16'hFFFF, 16'h0F0F, 3'd5, 16'hF0F0, 0, 0, 0);
      vecs[6]  = mk(4'd5,  16'h00FF, 16'h1234, 3'd6, 16'hFF00, 0, 0, 0);
      vecs[7]  = mk(4'd6,  16'h0001, 16'h0004, 3'd7, 16'h0010, 0, 0, 0);
      vecs[8]  = mk(4'd7,  16'h8000, 16'h000F, 3'd1, 16'h0001, 0, 0, 0);
      vecs[9]  = mk(4'd8,  16'h8000, 16'h0004, 3'd2, 16'hF800, 0, 0, 0);
      vecs[10] = mk(4'd9,  16'h8000, 16'h0001, 3'd3, 16'h0001, 0, 0, 0);
      vecs[11] = mk(4'd9,  16'h0001, 16'h8000, 3'd4, 16'h0000, 1, 0, 0);
      vecs[12] = mk(4'd10, 16'h1234, 16'hBEEF, 3'd5, 16'hBEEF, 0, 0, 0);
      vecs[13] = mk(4'd6,  16'h1234, 16'h0010, 3'd6, 16'h1234, 0, 0, 0);
      vecs[14] = mk(4'd1,  16'h8000, 16'h0001, 3'd7, 16'h7FFF, 0, 0, 1);
      vecs[15] = mk(4'd1,  16'h0003, 16'h0003, 3'd0, 16'h0000, 1, 0, 0);

      // Reset held low
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_reg_write", 32'(reg_write), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_flags", 32'({flag_zero, flag_carry, flag_ovf, div_err, illegal_op}), 0);
      chk("rst_state", 32'(dbg_state), 0);
      reset_n = 1'b1;

      // Back-to-back single-cycle table, one op per cycle
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); #1;
         chk("table_ready", 32'(in_ready), 1);
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
         exp_q.push_back(pack(vecs[i].rd, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v, 1'b0));
      end
      @(negedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #1;
      // Idle cycle: no strobe, flags hold from the last completion (zero result)
      chk("idle_no_write", 32'(reg_write), 0);
      chk("flag_zero_hold", 32'(flag_zero), 1);

      // Multi-cycle ops
      run_multi("mul_300", 4'd11, 16'd300, 16'd300, 3'd5, 16'h5F90, 1'b0);
      run_multi("mul_ffff", 4'd11, 16'hFFFF, 16'hFFFF, 3'd6, 16'h0001, 1'b0);
      run_multi("mul_zero", 4'd11, 16'h0000, 16'h1234, 3'd0, 16'h0000, 1'b0);
      run_multi("divu_100_7", 4'd12, 16'd100, 16'd7, 3'd2, 16'd14, 1'b0);
      run_multi("remu_100_7", 4'd13, 16'd100, 16'd7, 3'd3, 16'd2, 1'b0);
      run_multi("divu_9_0", 4'd12, 16'd9, 16'd0, 3'd4, 16'hFFFF, 1'b1);
      run_multi("remu_9_0", 4'd13, 16'd9, 16'd0, 3'd1, 16'd9, 1'b1);

      // div_err clears on the next completion
      run_single(mk(4'd0, 16'd1, 16'd1, 3'd1, 16'd2, 0, 0, 0));

      // Illegal opcode: pulse only, result unchanged from the ADD above
      @(negedge clk); #1;
      drive(4'd15, 16'hAAAA, 16'h5555, 3'd2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("illegal_pulse", 32'(illegal_op), 1);
      chk("illegal_no_write", 32'(reg_write), 0);
      chk("illegal_result_hold", 32'(result), 2);
      chk("illegal_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      chk("illegal_pulse_end", 32'(illegal_op), 0);

      // Reset asserted during a DIVU at iteration 8
      @(negedge clk); #1;
      drive(4'd12, 16'd100, 16'd7, 3'd6);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      chk("abort_busy", 32'(in_ready), 0);
      reset_n = 1'b0;
      #1;
      chk("async_ready", 32'(in_ready), 1);
      chk("async_result", 32'(result), 0);
      chk("async_write", 32'(reg_write), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_ready_after", 32'(in_ready), 1);

      // Unit still works after the abort
      run_single(mk(4'd1, 16'd10, 16'd3, 3'd7, 16'd7, 0, 0, 0));

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
